// File: rtl/bcd2binary_seq_if.sv
// ============================================================================
// Module   : bcd2binary_seq_if
// Function : Request/result bundle for the sequential BCD-to-binary converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bcd2binary_seq_if;
    logic        start;
    logic [15:0] packed_bcd;
    logic [13:0] out_binary;
    logic        busy;
    logic        done;
    logic        invalid;

    modport master (
        output start,
        output packed_bcd,
        input  out_binary,
        input  busy,
        input  done,
        input  invalid
    );

    modport slave (
        input  start,
        input  packed_bcd,
        output out_binary,
        output busy,
        output done,
        output invalid
    );
endinterface

`default_nettype wire

// File: rtl/bcd2binary_seq.sv
// ============================================================================
// Module   : bcd2binary_seq
// Function : Four-digit packed BCD to 14-bit binary, one digit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd2binary_seq (
    input  wire               clk,
    input  wire               rst,
    bcd2binary_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_shreg;
    logic [15:0] w_shreg_nxt;
    logic [13:0] r_acc;
    logic [13:0] w_acc_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [13:0] r_out;
    logic [13:0] w_out_nxt;
    logic        r_invalid;
    logic        w_invalid_nxt;
    logic        r_hold;
    logic        w_hold_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_bad_digit;
    logic [13:0] w_acc_step;

    assign w_bad_digit = (bus.packed_bcd[15:12] > 4'd9) || (bus.packed_bcd[11:8] > 4'd9) ||
                         (bus.packed_bcd[7:4]   > 4'd9) || (bus.packed_bcd[3:0]  > 4'd9);

    // acc*10 + digit as two shifts; the largest value reached is 999*10+9.
    assign w_acc_step = (r_acc << 3) + (r_acc << 1) + {10'd0, r_shreg[15:12]};

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_out_nxt     = r_out;
        w_invalid_nxt = r_invalid;
        w_hold_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_bad_digit) begin
                        // Rejected input waits one cycle in FINISH before done pulses.
                        w_invalid_nxt = 1'b1;
                        w_out_nxt     = 14'd0;
                        w_hold_nxt    = 1'b1;
                        w_state_nxt   = S_FINISH;
                    end else begin
                        w_shreg_nxt   = bus.packed_bcd;
                        w_acc_nxt     = 14'd0;
                        w_cnt_nxt     = 2'd3;
                        w_invalid_nxt = 1'b0;
                        w_state_nxt   = S_CONV;
                    end
                end
            end
            S_CONV: begin
                w_acc_nxt   = w_acc_step;
                w_shreg_nxt = {r_shreg[11:0], 4'd0};
                if (r_cnt == 2'd0) begin
                    w_out_nxt   = w_acc_step;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            S_FINISH: begin
                w_state_nxt = r_hold ? S_FINISH : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_FINISH) && !w_hold_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= 16'd0;
            r_acc     <= 14'd0;
            r_cnt     <= 2'd0;
            r_out     <= 14'd0;
            r_invalid <= 1'b0;
            r_hold    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out     <= w_out_nxt;
            r_invalid <= w_invalid_nxt;
            r_hold    <= w_hold_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.out_binary = r_out;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.invalid    = r_invalid;

endmodule

`default_nettype wire

// File: tb/tb_bcd2binary_seq.sv
// ============================================================================
// Module   : tb_bcd2binary_seq
// Function : Self-checking bench for bcd2binary_seq against a decimal model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd2binary_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bcd2binary_seq_if bus();

    bcd2binary_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    // Decimal meaning of the packed digits, or bad=1 if any digit exceeds 9.
    function automatic void model(input logic [15:0] bcd, output int value, output bit bad);
        int d3, d2, d1, d0;
        d3 = int'(bcd[15:12]);
        d2 = int'(bcd[11:8]);
        d1 = int'(bcd[7:4]);
        d0 = int'(bcd[3:0]);
        bad = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
        value = bad ? 0 : (1000 * d3 + 100 * d2 + 10 * d1 + d0);
    endfunction

    // One-shot request; observes 12 cycles and reports timing of done/busy.
    task automatic launch(input logic [15:0] bcd, output int lat, output int busy_cyc,
                          output int done_cyc);
        bus.packed_bcd = bcd;
        bus.start      = 1'b1;
        lat      = -1;
        busy_cyc = 0;
        done_cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) bus.start = 1'b0;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cyc++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.packed_bcd = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        checks += 4;
        if (bus.out_binary !== 14'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", bus.out_binary); end
        if (bus.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.invalid !== 1'b0)     begin errors++; $display("FAIL reset_invalid: got %b want 0", bus.invalid); end
    endtask

    task automatic test_zero();
        int lat, bc, dc;
        launch(16'h0000, lat, bc, dc);
        checks += 3;
        if (lat !== 5)                begin errors++; $display("FAIL zero_latency: got %0d want 5", lat); end
        if (bus.out_binary !== 14'd0) begin errors++; $display("FAIL zero_out: got %0d want 0", bus.out_binary); end
        if (bus.invalid !== 1'b0)     begin errors++; $display("FAIL zero_invalid: got %b want 0", bus.invalid); end
    endtask

    task automatic test_max();
        int lat, bc, dc;
        launch(16'h9999, lat, bc, dc);
        checks += 4;
        if (bus.out_binary !== 14'd9999) begin errors++; $display("FAIL max_out: got %0d want 9999", bus.out_binary); end
        if (dc !== 1)  begin errors++; $display("FAIL max_done_width: got %0d want 1", dc); end
        if (bc !== 5)  begin errors++; $display("FAIL max_busy_cycles: got %0d want 5", bc); end
        if (lat !== 5) begin errors++; $display("FAIL max_latency: got %0d want 5", lat); end
    endtask

    task automatic test_restart_ignored();
        int lat = -1, bc = 0, dc = 0;
        bus.packed_bcd = 16'h1234;
        bus.start      = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) bus.start = 1'b0;
            if (i == 2) begin bus.start = 1'b1; bus.packed_bcd = 16'h5678; end
            if (i == 3) bus.start = 1'b0;
            if (bus.busy) bc++;
            if (bus.done) begin dc++; if (lat < 0) lat = i; end
        end
        checks += 4;
        if (bus.out_binary !== 14'd1234) begin errors++; $display("FAIL restart_out: got %0d want 1234", bus.out_binary); end
        if (dc !== 1)  begin errors++; $display("FAIL restart_done_count: got %0d want 1", dc); end
        if (bc !== 5)  begin errors++; $display("FAIL restart_busy_cycles: got %0d want 5", bc); end
        if (lat !== 5) begin errors++; $display("FAIL restart_latency: got %0d want 5", lat); end
    endtask

    task automatic test_invalid();
        int lat, bc, dc;
        launch(16'h12A4, lat, bc, dc);
        checks += 4;
        if (bus.invalid !== 1'b1)     begin errors++; $display("FAIL inv_flag: got %b want 1", bus.invalid); end
        if (bus.out_binary !== 14'd0) begin errors++; $display("FAIL inv_out: got %0d want 0", bus.out_binary); end
        if (lat !== 2) begin errors++; $display("FAIL inv_latency: got %0d want 2", lat); end
        if (dc !== 1)  begin errors++; $display("FAIL inv_done_count: got %0d want 1", dc); end
    endtask

    task automatic test_reset_abort();
        int dc = 0;
        bus.packed_bcd = 16'h0042;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        if (bus.done) dc++;
        tick();
        if (bus.done) dc++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 3;
        if (bus.busy !== 1'b0)        begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (bus.out_binary !== 14'd0) begin errors++; $display("FAIL abort_out: got %0d want 0", bus.out_binary); end
        if (bus.invalid !== 1'b0)     begin errors++; $display("FAIL abort_invalid: got %b want 0", bus.invalid); end
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dc++;
            tick();
        end
        checks++;
        if (dc !== 0) begin errors++; $display("FAIL abort_done_seen: got %0d want 0", dc); end
    endtask

    task automatic test_random();
        int lat, bc, dc, want, want_lat;
        bit bad;
        logic [15:0] bcd;
        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < 4; d++)
                bcd[d*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                             : 4'($urandom_range(0, 9));
            model(bcd, want, bad);
            want_lat = bad ? 2 : 5;
            launch(bcd, lat, bc, dc);
            checks += 4;
            if (bus.out_binary !== 14'(want)) begin errors++; $display("FAIL rand_out %h: got %0d want %0d", bcd, bus.out_binary, want); end
            if (bus.invalid !== logic'(bad))   begin errors++; $display("FAIL rand_invalid %h: got %b want %b", bcd, bus.invalid, bad); end
            if (lat !== want_lat) begin errors++; $display("FAIL rand_latency %h: got %0d want %0d", bcd, lat, want_lat); end
            if (dc !== 1)         begin errors++; $display("FAIL rand_done_count %h: got %0d want 1", bcd, dc); end
        end
    endtask

    task automatic test_sweep();
        int prev_done = -1;
        int cyc = 0;
        int waited;
        bus.packed_bcd = to_bcd(0);
        bus.start      = 1'b1;
        for (int v = 0; v <= 9999; v++) begin
            waited = 0;
            do begin
                tick();
                cyc++;
                waited++;
            end while (!bus.done && waited < 20);
            bus.packed_bcd = to_bcd((v + 1) % 10000);
            checks++;
            if (!bus.done) begin
                errors++;
                $display("FAIL sweep_timeout at %0d: got no done want done", v);
                break;
            end
            if (bus.out_binary !== 14'(v) || bus.invalid !== 1'b0) begin
                errors++;
                $display("FAIL sweep_value: got %0d inv %b want %0d inv 0", bus.out_binary, bus.invalid, v);
            end
            if (prev_done >= 0 && (cyc - prev_done) != 6) begin
                errors++;
                $display("FAIL sweep_cadence at %0d: got %0d want 6", v, cyc - prev_done);
            end
            prev_done = cyc;
        end
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.packed_bcd = 16'h0000;
        test_reset();
        test_zero();
        test_max();
        test_restart_ignored();
        test_invalid();
        test_max();
        test_reset_abort();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd2binary_seq.md
BCD2BINARY_SEQ -- requirements
Module: bcd2binary_seq

Interface
REQ-001 The block SHALL have no parameters; it SHALL handle 4 BCD digits and a 14-bit binary result (max 9999).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to convert packed_bcd; sampled only in IDLE.
REQ-005 packed_bcd  input  16  four BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 out_binary  output  14  registered conversion result.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 done  output  1  one-cycle pulse marking a completed conversion.
REQ-009 invalid  output  1  registered flag: the last accepted input contained a nibble greater than 9.

Function
REQ-010 FSM states SHALL be IDLE, CONV and FINISH; reset SHALL enter IDLE.
REQ-011 IDLE, start=1, all nibbles at most 9: the block SHALL latch packed_bcd into a shift register and clear the 14-bit accumulator to 0.
REQ-012 For the start case in REQ-011, the block SHALL also set the digit counter to 3, clear invalid, and go to CONV.
REQ-013 IDLE, start=1, any nibble greater than 9: the block SHALL set invalid=1 and out_binary=0, and go to FINISH without entering CONV.
REQ-014 CONV, each cycle: acc <= (acc<<3) + (acc<<1) + shift_reg[15:12], then shift_reg <<= 4 and counter decrements.
REQ-015 No multiplier SHALL be used; the shift-add of REQ-014 SHALL be evaluated at a width of at least 14 bits, and no intermediate result SHALL exceed 9999.
REQ-016 On the CONV cycle with counter=0, the block SHALL load out_binary from the final accumulator value and go to FINISH.
REQ-017 FINISH: done=1 for exactly that cycle, then IDLE on the next edge.
REQ-018 Latency for a valid input: start sampled at edge k, out_binary valid after edge k+4, done high in the cycle between edges k+4 and k+5. That is 4 CONV cycles plus 1 FINISH cycle.
REQ-019 Latency for an invalid input: done high in the cycle between edges k+1 and k+2.
REQ-020 start while busy=1 SHALL be ignored, with no queuing; packed_bcd changes during CONV SHALL NOT affect the result.
REQ-021 start=1 held continuously SHALL launch a new conversion on the first IDLE cycle after each FINISH, giving one result per 6 cycles.
REQ-022 out_binary and invalid SHALL hold their values until the next accepted start.
REQ-023 done and busy SHALL be registered outputs, free of combinational paths from inputs.

Reset
REQ-024 When rst=1 at a rising edge, the following SHALL be forced regardless of state: state=IDLE, out_binary=0, done=0, busy=0, invalid=0, accumulator=0, counter=0, shift register=0.
REQ-025 Reset mid-conversion SHALL abort the conversion with no done pulse, and out_binary SHALL read 0.
REQ-026 rst SHALL take priority over start in the same cycle.

Verification
REQ-027 Reset, then start with packed_bcd=16'h0000 -> done after 5 cycles, out_binary=0, invalid=0.
REQ-028 start with packed_bcd=16'h9999 -> out_binary=14'd9999 (14'h270F), done exactly one cycle, busy high for 5 cycles.
REQ-029 start with 16'h1234, then start re-pulsed with 16'h5678 during CONV -> out_binary=1234, the second start is ignored, and busy drops after FINISH.
REQ-030 start with 16'h12A4 -> invalid=1, out_binary=0, done in the cycle after edge k+1.
REQ-031 start with 16'h0042, rst asserted 2 cycles later -> no done pulse, out_binary=0, busy=0 after the reset edge.
REQ-032 Exhaustive sweep 0..9999 fed as BCD, start held high -> every done pulse carries out_binary equal to the decimal value, with a 6-cycle cadence and invalid never set.
